// File: rtl/imm_ext_pkg.sv
// -----------------------------------------------------------------------------
// imm_ext_pkg
// Shared encodings for the immediate-extension stage:
//   imm_mode_e   - extension mode carried on in_mode
//   skid_state_e - occupancy of the output/skid register pair
// -----------------------------------------------------------------------------
package imm_ext_pkg;

    typedef enum logic [1:0] {
        IMM_SEXT      = 2'b00,
        IMM_ZEXT      = 2'b01,
        IMM_UPPER     = 2'b10,
        IMM_SEXT_SHL1 = 2'b11
    } imm_mode_e;

    // EMPTY: O invalid, S empty; ONE: O valid, S empty; TWO: O valid, S full.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b10
    } skid_state_e;

endpackage

// File: rtl/imm_ext_core.sv
// -----------------------------------------------------------------------------
// imm_ext_core
// Purely combinational widening of an IN_W-bit immediate to OUT_W bits.
// Ports:
//   i_imm  [IN_W]  raw immediate field
//   i_mode         extension mode (imm_mode_e)
//   o_imm  [OUT_W] extended immediate
// Legal parameter range: 2 <= IN_W < OUT_W.
// -----------------------------------------------------------------------------
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 4,
    parameter int OUT_W = 16
) (
    input  logic [IN_W-1:0]  i_imm,
    input  imm_mode_e        i_mode,
    output logic [OUT_W-1:0] o_imm
);

    logic [OUT_W-1:0] w_sext;

    assign w_sext = {{(OUT_W-IN_W){i_imm[IN_W-1]}}, i_imm};

    always_comb begin
        o_imm = w_sext;
        case (i_mode)
            IMM_SEXT:      o_imm = w_sext;
            IMM_ZEXT:      o_imm = {{(OUT_W-IN_W){1'b0}}, i_imm};
            IMM_UPPER:     o_imm = {i_imm, {(OUT_W-IN_W){1'b0}}};
            // Sign-extended value doubled; the original MSB falls off the top.
            IMM_SEXT_SHL1: o_imm = {w_sext[OUT_W-2:0], 1'b0};
            default:       o_imm = w_sext;
        endcase
    end

endmodule

// File: rtl/imm_extend_stage.sv
// -----------------------------------------------------------------------------
// imm_extend_stage
// Registered immediate-extension stage with a one-entry skid buffer.
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   flush             synchronous flush, discards everything incl. same-cycle accept
//   in_valid/in_ready upstream handshake; in_ready decodes registered state only
//   in_imm, in_mode   raw immediate and extension mode
//   in_tag            sideband tag carried with the item
//   out_valid/out_ready downstream handshake
//   out_imm, out_tag  extended immediate and its tag (held while stalled)
// Extension happens on the input side, so O and S both hold final results.
// -----------------------------------------------------------------------------
module imm_extend_stage
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 4,
    parameter int OUT_W = 16,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_imm,
    output logic [TAG_W-1:0] out_tag
);

    skid_state_e      r_state;
    skid_state_e      w_state_nxt;
    logic [OUT_W-1:0] r_out_imm;
    logic [TAG_W-1:0] r_out_tag;
    logic [OUT_W-1:0] r_skid_imm;
    logic [TAG_W-1:0] r_skid_tag;

    logic [OUT_W-1:0] w_ext_imm;
    logic             w_accept;
    logic             w_drain;
    logic             w_load_o_in;
    logic             w_load_o_skid;
    logic             w_load_s;

    imm_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .i_imm  (in_imm),
        .i_mode (imm_mode_e'(in_mode)),
        .o_imm  (w_ext_imm)
    );

    // Both handshake outputs come straight from the state register.
    assign in_ready  = (r_state != ST_TWO);
    assign out_valid = (r_state != ST_EMPTY);
    assign out_imm   = r_out_imm;
    assign out_tag   = r_out_tag;

    assign w_accept = in_valid && in_ready;
    assign w_drain  = out_valid && out_ready;

    always_comb begin
        w_state_nxt   = r_state;
        w_load_o_in   = 1'b0;
        w_load_o_skid = 1'b0;
        w_load_s      = 1'b0;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt = ST_ONE;
                        w_load_o_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_drain) begin
                        w_load_o_in = 1'b1;
                    end else if (w_accept) begin
                        w_state_nxt = ST_TWO;
                        w_load_s    = 1'b1;
                    end else if (w_drain) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so only a drain can move us.
                    if (w_drain) begin
                        w_state_nxt   = ST_ONE;
                        w_load_o_skid = 1'b1;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_EMPTY;
            r_out_imm  <= '0;
            r_out_tag  <= '0;
            r_skid_imm <= '0;
            r_skid_tag <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_o_in) begin
                r_out_imm <= w_ext_imm;
                r_out_tag <= in_tag;
            end else if (w_load_o_skid) begin
                r_out_imm <= r_skid_imm;
                r_out_tag <= r_skid_tag;
            end
            if (w_load_s) begin
                r_skid_imm <= w_ext_imm;
                r_skid_tag <= in_tag;
            end
        end
    end

endmodule
